// File: rtl/orb_reader.sv
// Read side of the orbital frame RAM: fetches one 12-bit word per request and
// shifts it out MSB-first with a framing strobe; slot 31 carries a packet marker.
module orb_reader #(
    parameter int NPACK  = 64,
    parameter int BITDIV = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_word_i,
    input  logic        sw_i,
    input  logic [11:0] rd_data_i,
    output logic [10:0] rd_addr_o,
    output logic        re_o,
    output logic        s_dat_o,
    output logic        s_strb_o,
    output logic        busy_o,
    output logic        ovr_o,
    output logic        test_o
);
    // state | meaning
    // IDLE  | waiting for a word request
    // FETCH | RAM read in flight (two clocks)
    // SHIFT | word being serialised, BITDIV clocks per bit
    typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;

    localparam logic [10:0] PTR_LAST = 11'(NPACK * 32 - 1);
    localparam int          DW       = $clog2(BITDIV);
    localparam logic [DW-1:0] DIV_LOAD = DW'(BITDIV - 1);

    logic [1:0]    req_sync_q, sw_sync_q;
    logic          req_prev_q, old_sw_q;

    state_t        state_q, state_d;
    logic [10:0]   rd_ptr_q, rd_ptr_d;
    logic [10:0]   rd_addr_q, rd_addr_d;
    logic          re_q, re_d;
    logic          s_dat_q, s_dat_d;
    logic          s_strb_q, s_strb_d;
    logic          ovr_q, ovr_d;
    logic          test_q, test_d;
    logic [11:0]   shreg_q, shreg_d;
    logic [3:0]    bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic          fetch_q, fetch_d;

    logic          req_edge, sw_chg;
    logic [11:0]   word;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_sync_q <= '0;
            sw_sync_q  <= '0;
            req_prev_q <= 1'b0;
            old_sw_q   <= 1'b0;
        end else begin
            req_sync_q <= {req_sync_q[0], req_word_i};
            sw_sync_q  <= {sw_sync_q[0], sw_i};
            req_prev_q <= req_sync_q[1];
            old_sw_q   <= sw_sync_q[1];
        end
    end

    assign req_edge = req_sync_q[1] & ~req_prev_q;
    assign sw_chg   = sw_sync_q[1] ^ old_sw_q;
    // Bit 11 set marks the unused slot 31; packer data never sets it.
    assign word     = (rd_ptr_q[4:0] == 5'd31) ? {1'b1, 5'd0, rd_ptr_q[10:5]} : rd_data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            rd_addr_q <= '0;
            re_q      <= 1'b0;
            s_dat_q   <= 1'b0;
            s_strb_q  <= 1'b0;
            ovr_q     <= 1'b0;
            test_q    <= 1'b0;
            shreg_q   <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            fetch_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_addr_q <= rd_addr_d;
            re_q      <= re_d;
            s_dat_q   <= s_dat_d;
            s_strb_q  <= s_strb_d;
            ovr_q     <= ovr_d;
            test_q    <= test_d;
            shreg_q   <= shreg_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            fetch_q   <= fetch_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rd_addr_d = rd_addr_q;
        re_d      = 1'b0;
        s_dat_d   = s_dat_q;
        s_strb_d  = s_strb_q;
        ovr_d     = ovr_q;
        test_d    = 1'b0;
        shreg_d   = shreg_q;
        bit_d     = bit_q;
        div_d     = div_q;
        fetch_d   = fetch_q;

        if (sw_chg) begin
            state_d  = IDLE;
            rd_ptr_d = '0;
            s_strb_d = 1'b0;
            s_dat_d  = 1'b0;
            ovr_d    = 1'b0;
            test_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_edge) begin
                        rd_addr_d = rd_ptr_q;
                        re_d      = 1'b1;
                        fetch_d   = 1'b0;
                        state_d   = FETCH;
                    end
                end
                FETCH: begin
                    if (req_edge) ovr_d = 1'b1;
                    if (fetch_q) begin
                        shreg_d  = word;
                        s_strb_d = 1'b1;
                        s_dat_d  = word[11];
                        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? 11'd0 : rd_ptr_q + 11'd1;
                        bit_d    = 4'd11;
                        div_d    = DIV_LOAD;
                        state_d  = SHIFT;
                    end else begin
                        fetch_d = 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_q != '0) begin
                        div_d = div_q - 1'b1;
                        if (req_edge) ovr_d = 1'b1;
                    end else if (bit_q != 4'd0) begin
                        bit_d   = bit_q - 4'd1;
                        div_d   = DIV_LOAD;
                        shreg_d = shreg_q << 1;
                        s_dat_d = shreg_q[10];
                        if (req_edge) ovr_d = 1'b1;
                    end else begin
                        // Last clock of bit 0: a request landing here is on time.
                        s_strb_d = 1'b0;
                        s_dat_d  = 1'b0;
                        state_d  = IDLE;
                        if (req_edge) begin
                            rd_addr_d = rd_ptr_q;
                            re_d      = 1'b1;
                            fetch_d   = 1'b0;
                            state_d   = FETCH;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rd_addr_o = rd_addr_q;
    assign re_o      = re_q;
    assign s_dat_o   = s_dat_q;
    assign s_strb_o  = s_strb_q;
    assign busy_o    = (state_q != IDLE);
    assign ovr_o     = ovr_q;
    assign test_o    = test_q;
endmodule

// File: tb/tb_orb_reader.sv
// Scoreboard bench for orb_reader: expected words are queued per request and
// compared by a serial monitor when each strobe window closes.
module tb_orb_reader;
    localparam int NPACK  = 2;
    localparam int BITDIV = 4;
    localparam int NW     = NPACK * 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        sw = 1'b0;
    logic [11:0] rd_data = '0;
    logic [10:0] rd_addr;
    logic        re, s_dat, s_strb, busy, ovr, test;

    logic [11:0] mem [0:63];

    typedef struct {
        logic [10:0] addr;
        logic [11:0] word;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int          checks = 0;
    int          errors = 0;
    int          re_cnt = 0;
    int          words_done = 0;
    logic        abort_pending = 1'b0;
    logic [10:0] last_addr = '0;
    logic [11:0] last_word = '0;
    int          last_len = 0;

    orb_reader #(.NPACK(NPACK), .BITDIV(BITDIV)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_word_i (req),
        .sw_i       (sw),
        .rd_data_i  (rd_data),
        .rd_addr_o  (rd_addr),
        .re_o       (re),
        .s_dat_o    (s_dat),
        .s_strb_o   (s_strb),
        .busy_o     (busy),
        .ovr_o      (ovr),
        .test_o     (test)
    );

    always #5 clk = ~clk;

    // RAM: data valid two edges after the RE edge.
    always @(posedge clk) if (re) rd_data <= mem[rd_addr[5:0]];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] model_word(input logic [10:0] a);
        if (a[4:0] == 5'd31) return {1'b1, 5'd0, a[10:5]};
        return mem[a[5:0]];
    endfunction

    function automatic logic [47:0] expand(input logic [11:0] w);
        logic [47:0] r;
        r = '0;
        for (int i = 11; i >= 0; i--) r = {r[43:0], {4{w[i]}}};
        return r;
    endfunction

    // Monitor
    logic [47:0] cap = '0;
    int          scnt = 0;
    int          re_w = 0;
    logic        strb_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cap = '0; scnt = 0; re_w = 0; strb_prev = 1'b0;
        end else begin
            if (re) begin
                if (re_w == 0) re_cnt++;
                re_w++;
                last_addr = rd_addr;
            end else if (re_w != 0) begin
                check("re_width", 48'(re_w), 48'd1);
                re_w = 0;
            end
            if (s_strb) begin
                cap = {cap[46:0], s_dat};
                scnt++;
            end else if (strb_prev) begin
                last_len = scnt;
                for (int k = 0; k < 12; k++) last_word[k] = cap[4*k];
                if (abort_pending) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    abort_pending = 1'b0;
                end else if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word: got %0h expected none", last_word);
                end else begin
                    e = exp_q.pop_front();
                    check("word_addr", 48'(last_addr), 48'(e.addr));
                    check("strb_len", 48'(scnt), 48'(12 * BITDIV));
                    check("serial", cap, expand(e.word));
                end
                words_done++;
                cap = '0;
                scnt = 0;
            end
            strb_prev = s_strb;
        end
    end

    task automatic pulse_req();
        @(negedge clk);
        req = 1'b1;
        repeat (4) @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done();
        int n0, t;
        n0 = words_done;
        t = 0;
        while (words_done == n0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (words_done == n0) begin
            checks++; errors++;
            $display("FAIL word_timeout: got no strobe end expected one");
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic push_exp(input logic [10:0] a);
        exp_t x;
        x.addr = a;
        x.word = model_word(a);
        exp_q.push_back(x);
    endtask

    task automatic do_word(input logic [10:0] a);
        push_exp(a);
        pulse_req();
        wait_done();
    endtask

    task automatic wait_strb();
        int t;
        t = 0;
        while (!s_strb && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("strb_seen", 48'(s_strb), 48'd1);
    endtask

    initial begin
        int n0, t;
        for (int i = 0; i < NW; i++) mem[i] = 12'(i << 3);
        mem[0] = 12'h5A8;

        repeat (3) @(negedge clk);
        check("rst_rd_addr", 48'(rd_addr), 48'd0);
        check("rst_re", 48'(re), 48'd0);
        check("rst_sdat", 48'(s_dat), 48'd0);
        check("rst_sstrb", 48'(s_strb), 48'd0);
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_ovr", 48'(ovr), 48'd0);
        check("rst_test", 48'(test), 48'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        do_word(11'd0);
        check("first_word", 48'(last_word), 48'h5A8);
        check("first_len", 48'(last_len), 48'd48);
        check("first_addr", 48'(last_addr), 48'd0);

        for (int a = 1; a < 32; a++) do_word(11'(a));
        check("word30", 48'(mem[30]), 48'h0F0);
        check("marker0", 48'(last_word), 48'h800);
        do_word(11'd32);
        check("addr32", 48'(last_addr), 48'd32);
        for (int a = 33; a < 64; a++) do_word(11'(a));
        check("marker1", 48'(last_word), 48'h801);
        do_word(11'd0);
        check("wrap_addr", 48'(last_addr), 48'd0);

        // Overrun: second request while shifting
        check("ovr_before", 48'(ovr), 48'd0);
        n0 = re_cnt;
        push_exp(11'd1);
        pulse_req();
        wait_strb();
        repeat (10) @(negedge clk);
        pulse_req();
        wait_done();
        check("ovr_set", 48'(ovr), 48'd1);
        check("ovr_re_count", 48'(re_cnt - n0), 48'd1);
        do_word(11'd2);
        check("after_ovr_addr", 48'(last_addr), 48'd2);
        check("ovr_sticky", 48'(ovr), 48'd1);

        // Bank toggle mid-word
        push_exp(11'd3);
        pulse_req();
        wait_strb();
        repeat (20) @(negedge clk);
        abort_pending = 1'b1;
        sw = 1'b1;
        t = 0;
        while (!test && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("test_pulse", 48'(test), 48'd1);
        check("sw_sstrb", 48'(s_strb), 48'd0);
        check("sw_sdat", 48'(s_dat), 48'd0);
        check("sw_ovr", 48'(ovr), 48'd0);
        check("sw_busy", 48'(busy), 48'd0);
        @(negedge clk);
        check("test_once", 48'(test), 48'd0);
        repeat (3) @(negedge clk);
        do_word(11'd0);
        check("sw_restart_addr", 48'(last_addr), 48'd0);

        // Reset one clock after the request edge
        push_exp(11'd1);
        @(negedge clk);
        req = 1'b1;
        t = 0;
        while (!re && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("rst_test_re", 48'(re), 48'd1);
        check("rst_test_addr", 48'(rd_addr), 48'd1);
        @(posedge clk);
        #1;
        check("busy_pre_rst", 48'(busy), 48'd1);
        rst_n = 1'b0;
        #1;
        check("async_busy", 48'(busy), 48'd0);
        check("async_re", 48'(re), 48'd0);
        check("async_sstrb", 48'(s_strb), 48'd0);
        check("async_addr", 48'(rd_addr), 48'd0);
        req = 1'b0;
        exp_q.delete();
        abort_pending = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_word(11'd0);
        check("post_rst_addr", 48'(last_addr), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/orb_reader.md
# orb_reader

Read-side counterpart of the orbital packer. Drains the dual-port frame RAM the packer fills (12-bit words, 32-word packets, channel 1 on even addresses, channel 2 on odd addresses, slot 31 of each packet unused), one word per request from the downstream frame generator. Each fetched word is shifted out MSB-first on a serial line with a framing strobe. Shares the packer's SW bank-toggle convention, so both ends restart at address 0 together.

## Interface
Parameters:
- NPACK, 64, packets per buffer; pointer wraps at NPACK*32 (power of two, at most 64)
- BITDIV, 4, clocks per serial bit (at least 2)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-low reset
- reqWord  in  1  word request from frame generator, asynchronous level; rising edge requests one word
- SW  in  1  bank-toggle level, asynchronous; any change restarts the reader
- RdData  in  12  RAM read data, valid 2 clocks after the RdAddr/RE edge
- RdAddr  out  11  RAM read address
- RE  out  1  RAM read enable, one-clock pulse
- sDat  out  1  serial data, MSB first
- sStrb  out  1  high while a word is being shifted
- busy  out  1  high whenever the FSM is not IDLE
- ovr  out  1  sticky overrun flag
- test  out  1  one-clock pulse on each SW change

## Operation
- reqWord and SW pass through 2-FF synchronisers, giving syncReq[1] and syncSW[1].
- A request is a rising edge: syncReq[1]=1 while the previous value was 0.
- rdPtr is 11 bits; pack = rdPtr[10:5]; slot = rdPtr[4:0].
- FSM states are IDLE, FETCH and SHIFT.
- IDLE, on request:
  - RdAddr <= rdPtr, RE <= 1, go to FETCH.
  - Requests are ignored while not in IDLE. Such a request sets ovr.
- FETCH:
  - RE <= 0 after one clock.
  - On the second clock, load the shift register with the word selected by slot:
    - slot != 31: RdData.
    - slot == 31: marker {1'b1, 5'd0, pack}. Bit 11 set distinguishes the marker from data, since packer data always has bit 11 = 0.
  - In the same clock: sStrb <= 1, sDat <= word[11], increment rdPtr, go to SHIFT.
- SHIFT:
  - The bit counter (0..11) and divider counter (0..BITDIV-1) run.
  - Each bit is held exactly BITDIV clocks, MSB first.
  - After bit 0 has been held BITDIV clocks: sStrb <= 0, sDat <= 0, go to IDLE.
- rdPtr wrap: after NPACK*32-1, rdPtr returns to 0.
- SW change, detected when syncSW[1] != oldSW:
  - Highest priority; overrides any state.
  - rdPtr <= 0, FSM <= IDLE.
  - sStrb, sDat, RE <= 0; ovr <= 0.
  - test <= 1 for one clock.
  - A request in the same clock is dropped.
- Reset values: RdAddr 0, RE 0, sDat 0, sStrb 0, busy 0, ovr 0, test 0. Also rdPtr 0, FSM IDLE, oldSW 0, synchronisers 0.

## Timing
- Let E be the clk edge at which the request edge is detected. That is 2–3 clocks after reqWord rises, depending on synchroniser phase.
- Edge E: RdAddr updates and RE = 1. RE is high for exactly one clock (E to E+1).
- Edge E+2: RdData is sampled. sStrb rises, sDat carries bit 11, rdPtr increments.
- Bit k (11 down to 0) is on sDat from E+2+(11−k)*BITDIV for BITDIV clocks.
- sStrb is high for exactly 12*BITDIV clocks. It falls at E+2+12*BITDIV, where FSM also returns to IDLE.
- Minimum request spacing without overrun is 12*BITDIV+2 clocks after E. A new request may be detected on the same edge sStrb falls.
- busy is high from E to E+2+12*BITDIV.
- Reset asserted mid-word: all outputs 0 immediately (asynchronous). After release, the reader starts from address 0.

## Test plan
- Reset then single request, RAM[0]=12'h5A8, BITDIV=4:
  - RdAddr=0 and RE pulses one clock.
  - 48 clocks later sStrb has been high for exactly 48 clocks.
  - sDat sequence is 0101_1010_1000.
- 32 spaced requests, RAM[n]=n<<3:
  - Words 0..30 match RAM.
  - Word 31 is marker 12'h800.
  - Request 33 reads RdAddr=32 and its slot-31 marker is 12'h801.
- Wrap with NPACK=2:
  - 64 requests, then the 65th shows RdAddr=0.
  - Marker at address 63 is 12'h801.
- Request pulse during SHIFT:
  - ovr=1, no RE, current word completes unchanged.
  - A next spaced request reads the following address.
- SW toggle mid-SHIFT at bit 6:
  - test pulses one clock, sStrb/sDat drop to 0 next clock, ovr clears.
  - Next request reads RdAddr=0.
- rst asserted at E+1:
  - RE, sStrb, busy go 0 without clock.
  - After release, first request reads address 0.
